// File: rtl/ccc_handler.sv
// CCC sequencing engine: walks a broadcast or direct CCC frame and its data phase,
// steering TX/RX modes, SCL stall requests and register file accesses.
module ccc_handler (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_engine_en,
    input  logic [4:0] i_bitcnt_number,
    input  logic       i_tx_mode_done,
    input  logic       i_rx_mode_done,
    input  logic       i_rx_second_pre,
    input  logic       i_rx_error,
    input  logic       i_sclstall_stall_done,
    input  logic       i_frmcnt_last_frame,
    input  logic       i_regf_RnW,
    input  logic [7:0] i_regf_CMD,
    input  logic [4:0] i_regf_DEV_INDEX,
    input  logic [2:0] i_regf_DTT,
    input  logic       i_regf_DBP,
    input  logic [2:0] i_regf_CMD_ATTR,
    input  logic       i_regf_TOC,
    input  logic       i_regf_WROC,
    input  logic       i_regf_SRE,
    output logic       o_tx_en,
    output logic [3:0] o_tx_mode,
    output logic       o_rx_en,
    output logic [2:0] o_rx_mode,
    output logic       o_sclstall_en,
    output logic [3:0] o_sclstall_code,
    output logic       o_bitcnt_en,
    output logic       o_frmcnt_en,
    output logic       o_sdahand_pp_od,
    output logic       o_regf_wr_en,
    output logic       o_regf_rd_en,
    output logic [7:0] o_regf_addr,
    output logic [7:0] o_txrx_addr_ccc,
    output logic       o_engine_odd,
    output logic       o_engine_done
);

    localparam logic [3:0] TX_PRE_CMD   = 4'd0;
    localparam logic [3:0] TX_PRE_DATA  = 4'd1;
    localparam logic [3:0] TX_CMD_WORD  = 4'd2;
    localparam logic [3:0] TX_CCC_BYTE  = 4'd3;
    localparam logic [3:0] TX_DEF_BYTE  = 4'd4;
    localparam logic [3:0] TX_ZERO_BYTE = 4'd5;
    localparam logic [3:0] TX_REGF_BYTE = 4'd6;
    localparam logic [3:0] TX_PARITY    = 4'd7;
    localparam logic [3:0] TX_RESTART   = 4'd8;
    localparam logic [3:0] TX_EXIT      = 4'd9;
    localparam logic [2:0] RX_PREAMBLE  = 3'd0;
    localparam logic [2:0] RX_DATA_BYTE = 3'd1;
    localparam logic [2:0] RX_PARITY    = 3'd2;

    typedef enum logic [4:0] {
        IDLE, PRE_CMD, CMD_WORD, CMD_PAR, PRE_CCC, CCC_BYTE, DEF_BYTE, CCC_PAR,
        RESTART, PRE_ADDR, ADDR_WORD, ADDR_PAR,
        WR_PRE, WR_BYTE1, WR_BYTE2, WR_PAR,
        RD_STALL, RD_PRE, RD_BYTE1, RD_BYTE2, RD_PAR,
        EXIT, DONE
    } state_t;

    state_t     state, state_nx, data_entry;
    logic       armed, start, byte_done, word_last, unused_ok;
    logic [7:0] cmd_q, byte_idx;
    logic       rnw_q, dbp_q, toc_q, wroc_q, sre_q;
    logic [4:0] dev_q;
    logic [2:0] dtt_q, attr_q, bytes_left;

    // A new transfer needs i_engine_en to have been low since the last start.
    assign start      = (state == IDLE) && i_engine_en && armed;
    assign byte_done  = ((state == WR_BYTE1 || state == WR_BYTE2) && i_tx_mode_done) ||
                        ((state == RD_BYTE1 || state == RD_BYTE2) && i_rx_mode_done && !i_rx_error);
    assign word_last  = (bytes_left == 3'd0) || i_frmcnt_last_frame;
    assign data_entry = (dtt_q == 3'd0)     ? EXIT :
                        (cmd_q[7] && rnw_q) ? RD_STALL : WR_PRE;
    assign unused_ok  = ^{attr_q, toc_q, wroc_q, sre_q, i_bitcnt_number};

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state      <= IDLE;
            armed      <= 1'b1;
            cmd_q      <= 8'd0;
            rnw_q      <= 1'b0;
            dev_q      <= 5'd0;
            dtt_q      <= 3'd0;
            dbp_q      <= 1'b0;
            attr_q     <= 3'd0;
            toc_q      <= 1'b0;
            wroc_q     <= 1'b0;
            sre_q      <= 1'b0;
            byte_idx   <= 8'd0;
            bytes_left <= 3'd0;
        end else begin
            state <= state_nx;
            if (!i_engine_en)
                armed <= 1'b1;
            else if (start)
                armed <= 1'b0;
            if (start) begin
                cmd_q      <= i_regf_CMD;
                rnw_q      <= i_regf_RnW;
                dev_q      <= i_regf_DEV_INDEX;
                dtt_q      <= i_regf_DTT;
                dbp_q      <= i_regf_DBP;
                attr_q     <= i_regf_CMD_ATTR;
                toc_q      <= i_regf_TOC;
                wroc_q     <= i_regf_WROC;
                sre_q      <= i_regf_SRE;
                byte_idx   <= {7'd0, i_regf_DBP};
                bytes_left <= i_regf_DTT;
            end else if (byte_done) begin
                byte_idx <= byte_idx + 8'd1;
                if (bytes_left != 3'd0)
                    bytes_left <= bytes_left - 3'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = PRE_CMD;
            PRE_CMD:   if (i_tx_mode_done) state_nx = CMD_WORD;
            CMD_WORD:  if (i_tx_mode_done) state_nx = CMD_PAR;
            CMD_PAR:   if (i_tx_mode_done) state_nx = PRE_CCC;
            PRE_CCC:   if (i_tx_mode_done) state_nx = CCC_BYTE;
            CCC_BYTE:  if (i_tx_mode_done) state_nx = DEF_BYTE;
            DEF_BYTE:  if (i_tx_mode_done) state_nx = CCC_PAR;
            CCC_PAR:   if (i_tx_mode_done) state_nx = cmd_q[7] ? RESTART : data_entry;
            RESTART:   if (i_tx_mode_done) state_nx = PRE_ADDR;
            PRE_ADDR:  if (i_tx_mode_done) state_nx = ADDR_WORD;
            ADDR_WORD: if (i_tx_mode_done) state_nx = ADDR_PAR;
            ADDR_PAR:  if (i_tx_mode_done) state_nx = data_entry;
            WR_PRE:    if (i_tx_mode_done) state_nx = WR_BYTE1;
            WR_BYTE1:  if (i_tx_mode_done) state_nx = WR_BYTE2;
            WR_BYTE2:  if (i_tx_mode_done) state_nx = WR_PAR;
            WR_PAR:    if (i_tx_mode_done) state_nx = word_last ? EXIT : WR_PRE;
            RD_STALL:  if (i_sclstall_stall_done) state_nx = RD_PRE;
            RD_PRE: begin
                if (i_rx_error)
                    state_nx = EXIT;
                else if (i_rx_mode_done)
                    state_nx = i_rx_second_pre ? EXIT : RD_BYTE1;
            end
            RD_BYTE1: begin
                if (i_rx_error)          state_nx = EXIT;
                else if (i_rx_mode_done) state_nx = RD_BYTE2;
            end
            RD_BYTE2: begin
                if (i_rx_error)          state_nx = EXIT;
                else if (i_rx_mode_done) state_nx = RD_PAR;
            end
            RD_PAR: begin
                if (i_rx_error)          state_nx = EXIT;
                else if (i_rx_mode_done) state_nx = word_last ? RD_PRE_OR_EXIT(word_last) : RD_PRE;
            end
            EXIT:      if (i_tx_mode_done) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Odd payload: the second byte of the final word is a pad, so no register access.
    always_comb begin
        o_tx_en         = 1'b0;
        o_tx_mode       = 4'd0;
        o_rx_en         = 1'b0;
        o_rx_mode       = 3'd0;
        o_sclstall_en   = 1'b0;
        o_sclstall_code = 4'd0;
        o_bitcnt_en     = (state != IDLE);
        o_sdahand_pp_od = (state != IDLE);
        o_frmcnt_en     = 1'b0;
        o_regf_wr_en    = 1'b0;
        o_regf_rd_en    = 1'b0;
        o_regf_addr     = 8'd0;
        o_txrx_addr_ccc = 8'd0;
        o_engine_odd    = (state != IDLE) && dtt_q[0];
        o_engine_done   = 1'b0;
        case (state)
            PRE_CMD, PRE_ADDR: begin
                o_tx_en = 1'b1; o_tx_mode = TX_PRE_CMD;
            end
            CMD_WORD: begin
                o_tx_en = 1'b1; o_tx_mode = TX_CMD_WORD; o_txrx_addr_ccc = 8'h7E;
            end
            ADDR_WORD: begin
                o_tx_en      = 1'b1; o_tx_mode = TX_CMD_WORD;
                o_regf_rd_en = 1'b1; o_regf_addr = 8'h40 + {3'd0, dev_q};
            end
            CMD_PAR, CCC_PAR, ADDR_PAR: begin
                o_tx_en = 1'b1; o_tx_mode = TX_PARITY;
            end
            PRE_CCC, WR_PRE: begin
                o_tx_en = 1'b1; o_tx_mode = TX_PRE_DATA;
            end
            CCC_BYTE: begin
                o_tx_en = 1'b1; o_tx_mode = TX_CCC_BYTE; o_txrx_addr_ccc = cmd_q;
            end
            DEF_BYTE: begin
                o_tx_en = 1'b1; o_tx_mode = dbp_q ? TX_DEF_BYTE : TX_ZERO_BYTE;
            end
            RESTART: begin
                o_tx_en = 1'b1; o_tx_mode = TX_RESTART;
            end
            WR_BYTE1: begin
                o_tx_en      = 1'b1; o_tx_mode = TX_REGF_BYTE;
                o_regf_rd_en = 1'b1; o_regf_addr = byte_idx;
            end
            WR_BYTE2: begin
                o_tx_en = 1'b1;
                if (bytes_left != 3'd0) begin
                    o_tx_mode    = TX_REGF_BYTE;
                    o_regf_rd_en = 1'b1;
                    o_regf_addr  = byte_idx;
                end else begin
                    o_tx_mode = TX_ZERO_BYTE;
                end
            end
            WR_PAR: begin
                o_tx_en = 1'b1; o_tx_mode = TX_PARITY; o_frmcnt_en = i_tx_mode_done;
            end
            RD_STALL: begin
                o_rx_en       = 1'b1; o_rx_mode = RX_PREAMBLE;
                o_sclstall_en = 1'b1; o_sclstall_code = 4'd1;
            end
            RD_PRE: begin
                o_rx_en = 1'b1; o_rx_mode = RX_PREAMBLE;
            end
            RD_BYTE1: begin
                o_rx_en      = 1'b1; o_rx_mode = RX_DATA_BYTE;
                o_regf_wr_en = 1'b1; o_regf_addr = byte_idx;
            end
            RD_BYTE2: begin
                o_rx_en      = 1'b1; o_rx_mode = RX_DATA_BYTE;
                o_regf_wr_en = (bytes_left != 3'd0); o_regf_addr = byte_idx;
            end
            RD_PAR: begin
                o_rx_en     = 1'b1; o_rx_mode = RX_PARITY;
                o_frmcnt_en = i_rx_mode_done && !i_rx_error;
            end
            EXIT: begin
                o_tx_en = 1'b1; o_tx_mode = TX_EXIT;
            end
            DONE: begin
                o_tx_en = 1'b1; o_tx_mode = TX_EXIT; o_engine_done = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic state_t RD_PRE_OR_EXIT(input logic last);
        return last ? EXIT : RD_PRE;
    endfunction

endmodule

// File: tb/tb_ccc_handler.sv
// Directed bench for ccc_handler: walks broadcast, direct write and direct read
// transfers against hand-written mode sequences.
module tb_ccc_handler;

    logic       i_sys_clk, i_sys_rst, i_engine_en;
    logic [4:0] i_bitcnt_number;
    logic       i_tx_mode_done, i_rx_mode_done, i_rx_second_pre, i_rx_error;
    logic       i_sclstall_stall_done, i_frmcnt_last_frame, i_regf_RnW;
    logic [7:0] i_regf_CMD;
    logic [4:0] i_regf_DEV_INDEX;
    logic [2:0] i_regf_DTT, i_regf_CMD_ATTR;
    logic       i_regf_DBP, i_regf_TOC, i_regf_WROC, i_regf_SRE;
    logic       o_tx_en, o_rx_en, o_sclstall_en, o_bitcnt_en, o_frmcnt_en, o_sdahand_pp_od;
    logic [3:0] o_tx_mode, o_sclstall_code;
    logic [2:0] o_rx_mode;
    logic       o_regf_wr_en, o_regf_rd_en, o_engine_odd, o_engine_done;
    logic [7:0] o_regf_addr, o_txrx_addr_ccc;
    logic [36:0] all_outs;

    int errors;
    int checks;
    int exp_mode[$];
    int exp_rd[$];
    int exp_ccc[$];

    ccc_handler dut (
        .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_engine_en(i_engine_en),
        .i_bitcnt_number(i_bitcnt_number), .i_tx_mode_done(i_tx_mode_done),
        .i_rx_mode_done(i_rx_mode_done), .i_rx_second_pre(i_rx_second_pre),
        .i_rx_error(i_rx_error), .i_sclstall_stall_done(i_sclstall_stall_done),
        .i_frmcnt_last_frame(i_frmcnt_last_frame), .i_regf_RnW(i_regf_RnW),
        .i_regf_CMD(i_regf_CMD), .i_regf_DEV_INDEX(i_regf_DEV_INDEX),
        .i_regf_DTT(i_regf_DTT), .i_regf_DBP(i_regf_DBP),
        .i_regf_CMD_ATTR(i_regf_CMD_ATTR), .i_regf_TOC(i_regf_TOC),
        .i_regf_WROC(i_regf_WROC), .i_regf_SRE(i_regf_SRE),
        .o_tx_en(o_tx_en), .o_tx_mode(o_tx_mode), .o_rx_en(o_rx_en), .o_rx_mode(o_rx_mode),
        .o_sclstall_en(o_sclstall_en), .o_sclstall_code(o_sclstall_code),
        .o_bitcnt_en(o_bitcnt_en), .o_frmcnt_en(o_frmcnt_en),
        .o_sdahand_pp_od(o_sdahand_pp_od), .o_regf_wr_en(o_regf_wr_en),
        .o_regf_rd_en(o_regf_rd_en), .o_regf_addr(o_regf_addr),
        .o_txrx_addr_ccc(o_txrx_addr_ccc), .o_engine_odd(o_engine_odd),
        .o_engine_done(o_engine_done)
    );

    assign all_outs = {o_tx_en, o_tx_mode, o_rx_en, o_rx_mode, o_sclstall_en, o_sclstall_code,
                       o_bitcnt_en, o_frmcnt_en, o_sdahand_pp_od, o_regf_wr_en, o_regf_rd_en,
                       o_regf_addr, o_txrx_addr_ccc, o_engine_odd, o_engine_done};

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge with i_engine_en low; returns one cycle into PRE_CMD.
    task automatic applyStimulus(input logic [7:0] cmd, input logic rnw, input logic [2:0] dtt,
                                 input logic dbp, input logic [4:0] dev);
        i_regf_CMD       = cmd;
        i_regf_RnW       = rnw;
        i_regf_DTT       = dtt;
        i_regf_DBP       = dbp;
        i_regf_DEV_INDEX = dev;
        i_tx_mode_done   = 1'b1;
        i_engine_en      = 1'b1;
        @(negedge i_sys_clk);
    endtask

    task automatic runSteps(input string tag);
        for (int i = 0; i < exp_mode.size(); i++) begin
            #1;
            checkOutput($sformatf("%s tx_en[%0d]", tag, i), 64'(o_tx_en), 64'd1);
            checkOutput($sformatf("%s tx_mode[%0d]", tag, i), 64'(o_tx_mode), 64'(exp_mode[i]));
            checkOutput($sformatf("%s rd_en[%0d]", tag, i), 64'(o_regf_rd_en), 64'(exp_rd[i] >= 0));
            if (exp_rd[i] >= 0)
                checkOutput($sformatf("%s rd_addr[%0d]", tag, i), 64'(o_regf_addr), 64'(exp_rd[i]));
            if (exp_ccc[i] >= 0)
                checkOutput($sformatf("%s txrx[%0d]", tag, i), 64'(o_txrx_addr_ccc), 64'(exp_ccc[i]));
            @(negedge i_sys_clk);
        end
    endtask

    // DONE pulse, then IDLE held even though i_engine_en is still high.
    task automatic checkDone(input string tag);
        #1;
        checkOutput({tag, " done"}, 64'(o_engine_done), 64'd1);
        checkOutput({tag, " done_mode"}, 64'(o_tx_mode), 64'd9);
        @(negedge i_sys_clk);
        #1;
        checkOutput({tag, " idle_done"}, 64'(o_engine_done), 64'd0);
        checkOutput({tag, " idle_outs"}, 64'(all_outs), 64'd0);
        @(negedge i_sys_clk);
        #1;
        checkOutput({tag, " no_restart"}, 64'(all_outs), 64'd0);
        i_engine_en = 1'b0;
        @(negedge i_sys_clk);
    endtask

    task automatic setReadPrefix(input logic [7:0] cmd);
        exp_mode = '{0, 2, 7, 1, 3, 5, 7, 8, 0, 2, 7};
        exp_rd   = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 'h43, -1};
        exp_ccc  = '{-1, 'h7E, -1, -1, 32'(cmd), -1, -1, -1, -1, -1, -1};
    endtask

    initial begin
        int rx_modes[4] = '{0, 1, 1, 2};
        int rx_wr[4]    = '{-1, 0, 1, -1};
        errors = 0; checks = 0;
        i_sys_rst = 1'b0; i_engine_en = 1'b0; i_bitcnt_number = 5'd0;
        i_tx_mode_done = 1'b0; i_rx_mode_done = 1'b0; i_rx_second_pre = 1'b0; i_rx_error = 1'b0;
        i_sclstall_stall_done = 1'b0; i_frmcnt_last_frame = 1'b0; i_regf_RnW = 1'b0;
        i_regf_CMD = 8'd0; i_regf_DEV_INDEX = 5'd0; i_regf_DTT = 3'd0; i_regf_DBP = 1'b0;
        i_regf_CMD_ATTR = 3'd5; i_regf_TOC = 1'b1; i_regf_WROC = 1'b0; i_regf_SRE = 1'b1;
        repeat (3) @(negedge i_sys_clk);
        #1 checkOutput("reset outs", 64'(all_outs), 64'd0);
        i_sys_rst = 1'b1;
        @(negedge i_sys_clk);

        $display("[TB] direct write CMD=89 DTT=2");
        applyStimulus(8'h89, 1'b0, 3'd2, 1'b0, 5'd9);
        exp_mode = '{0, 2, 7, 1, 3, 5, 7, 8, 0, 2, 7, 1, 6, 6, 7, 9};
        exp_rd   = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 'h49, -1, -1, 0, 1, -1, -1};
        exp_ccc  = '{-1, 'h7E, -1, -1, 'h89, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        runSteps("dwr");
        checkOutput("dwr odd", 64'(o_engine_odd), 64'd0);
        checkDone("dwr");

        $display("[TB] broadcast CMD=06 DBP=1 DTT=3");
        applyStimulus(8'h06, 1'b0, 3'd3, 1'b1, 5'd0);
        exp_mode = '{0, 2, 7, 1, 3, 4, 7, 1, 6, 6, 7, 1, 6, 5, 7, 9};
        exp_rd   = '{-1, -1, -1, -1, -1, -1, -1, -1, 1, 2, -1, -1, 3, -1, -1, -1};
        exp_ccc  = '{-1, 'h7E, -1, -1, 'h06, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        runSteps("bc");
        checkOutput("bc odd", 64'(o_engine_odd), 64'd1);
        checkDone("bc");

        $display("[TB] broadcast last_frame cut, en dropped mid-transfer");
        i_frmcnt_last_frame = 1'b1;
        applyStimulus(8'h01, 1'b0, 3'd4, 1'b0, 5'd0);
        i_engine_en = 1'b0;
        exp_mode = '{0, 2, 7, 1, 3, 5, 7, 1, 6, 6, 7, 9};
        exp_rd   = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 1, -1, -1};
        exp_ccc  = '{-1, 'h7E, -1, -1, 'h01, -1, -1, -1, -1, -1, -1, -1};
        runSteps("lf");
        checkDone("lf");
        i_frmcnt_last_frame = 1'b0;

        $display("[TB] broadcast DTT=0");
        applyStimulus(8'h2A, 1'b0, 3'd0, 1'b0, 5'd0);
        exp_mode = '{0, 2, 7, 1, 3, 5, 7, 9};
        exp_rd   = '{-1, -1, -1, -1, -1, -1, -1, -1};
        exp_ccc  = '{-1, 'h7E, -1, -1, 'h2A, -1, -1, -1};
        runSteps("d0");
        checkDone("d0");

        $display("[TB] direct read CMD=8B DTT=2");
        applyStimulus(8'h8B, 1'b1, 3'd2, 1'b0, 5'd3);
        setReadPrefix(8'h8B);
        runSteps("rd");
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("rd stall_en[%0d]", c), 64'(o_sclstall_en), 64'd1);
            checkOutput($sformatf("rd stall_code[%0d]", c), 64'(o_sclstall_code), 64'd1);
            if (c == 2) i_sclstall_stall_done = 1'b1;
            @(negedge i_sys_clk);
        end
        i_sclstall_stall_done = 1'b0;
        i_rx_mode_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("rd rx_en[%0d]", i), 64'({o_rx_en, o_tx_en}), 64'b10);
            checkOutput($sformatf("rd rx_mode[%0d]", i), 64'(o_rx_mode), 64'(rx_modes[i]));
            checkOutput($sformatf("rd wr_en[%0d]", i), 64'(o_regf_wr_en), 64'(rx_wr[i] >= 0));
            if (rx_wr[i] >= 0)
                checkOutput($sformatf("rd wr_addr[%0d]", i), 64'(o_regf_addr), 64'(rx_wr[i]));
            checkOutput($sformatf("rd frmcnt[%0d]", i), 64'(o_frmcnt_en), 64'(i == 3));
            @(negedge i_sys_clk);
        end
        #1 checkOutput("rd exit", 64'({o_tx_en, o_tx_mode}), {59'd0, 1'b1, 4'd9});
        i_rx_mode_done = 1'b0;
        @(negedge i_sys_clk);
        checkDone("rd");

        $display("[TB] direct read aborted by second preamble");
        applyStimulus(8'h8B, 1'b1, 3'd2, 1'b0, 5'd3);
        runSteps("ab");
        i_sclstall_stall_done = 1'b1;
        @(negedge i_sys_clk);
        i_sclstall_stall_done = 1'b0;
        i_rx_mode_done = 1'b1;
        i_rx_second_pre = 1'b1;
        #1 checkOutput("ab pre", 64'({o_rx_en, o_rx_mode, o_regf_wr_en}), 64'b10000);
        @(negedge i_sys_clk);
        #1 checkOutput("ab exit", 64'({o_tx_en, o_tx_mode, o_regf_wr_en}), {58'd0, 1'b1, 4'd9, 1'b0});
        i_rx_mode_done = 1'b0;
        i_rx_second_pre = 1'b0;
        @(negedge i_sys_clk);
        checkDone("ab");

        $display("[TB] direct read with RX error");
        applyStimulus(8'h8B, 1'b1, 3'd2, 1'b0, 5'd3);
        runSteps("er");
        i_sclstall_stall_done = 1'b1;
        @(negedge i_sys_clk);
        i_sclstall_stall_done = 1'b0;
        i_rx_mode_done = 1'b1;
        @(negedge i_sys_clk);
        #1 checkOutput("er byte1", 64'(o_rx_mode), 64'd1);
        i_rx_mode_done = 1'b0;
        i_rx_error = 1'b1;
        @(negedge i_sys_clk);
        #1 checkOutput("er exit", 64'({o_tx_en, o_tx_mode, o_rx_en}), {58'd0, 1'b1, 4'd9, 1'b0});
        i_rx_error = 1'b0;
        @(negedge i_sys_clk);
        checkDone("er");

        $display("[TB] asynchronous reset mid direct write");
        applyStimulus(8'h89, 1'b0, 3'd2, 1'b0, 5'd9);
        repeat (10) @(negedge i_sys_clk);
        #1 checkOutput("rst busy", 64'(o_tx_en), 64'd1);
        #2 i_sys_rst = 1'b0;
        #1 checkOutput("rst async outs", 64'(all_outs), 64'd0);
        @(negedge i_sys_clk);
        i_engine_en = 1'b0;
        i_sys_rst = 1'b1;
        @(negedge i_sys_clk);
        #1 checkOutput("rst idle outs", 64'(all_outs), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
